// File: rtl/btn_conditioner.sv
// Push-button front end: per-bit 2-FF synchroniser, debouncer and press detector.
// Define BTN_DIR_ONEHOT_EN to arbitrate the four direction bits down to one owner.
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] btn_raw,
    output logic [4:0] btn_level,
    output logic [4:0] btn_press,
    output logic       any_dir
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [4:0]       s1;
    logic [4:0]       s2;
    logic [4:0]       d;
    logic [4:0]       d_next;
    logic [CNT_W-1:0] cnt      [5];
    logic [CNT_W-1:0] cnt_next [5];
    logic [4:0]       level_next;
    logic [4:0]       press_next;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
        end
    end

    // Any cycle where s2 agrees with d restarts the count, so short glitches never land.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        d_next = d;
        for (int i = 0; i < 5; i++) begin
            cnt_next[i] = '0;
            if (s2[i] != d[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    d_next[i] = s2[i];
                end else begin
                    cnt_next[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            d <= '0;
            // NOTE: the counter array is only five entries of flops, not a RAM, so it is reset like any register.
            for (int i = 0; i < 5; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
            d <= d_next;
            for (int i = 0; i < 5; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

`ifdef BTN_DIR_ONEHOT_EN
    logic [4:1] own;
    logic [4:1] own_next;

    // Current owner keeps the bus while held; otherwise lowest index (up first) wins.
    always_comb begin
        own_next = '0;
        if ((own & d_next[4:1]) != '0) begin
            own_next = own;
        end else begin
            for (int k = 4; k >= 1; k--) begin
                if (d_next[k]) begin
                    own_next    = '0;
                    own_next[k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            own <= '0;
        end else begin
            own <= own_next;
        end
    end

    always_comb begin
        level_next = {own_next, d_next[0]};
        press_next = {(own_next != own) ? own_next : 4'b0000, d_next[0] & ~d[0]};
    end
`else
    always_comb begin
        level_next = d_next;
        press_next = d_next & ~d;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            btn_level <= '0;
            btn_press <= '0;
        end else begin
            btn_level <= level_next;
            btn_press <= press_next;
        end
    end

    assign any_dir = |btn_level[4:1];

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner: a window-based reference model predicts each
// cycle's outputs; a negedge monitor compares them. Honours BTN_DIR_ONEHOT_EN like the DUT.
module tb_btn_conditioner;

    localparam int DEB = 4;
    localparam int CW  = 3;

    typedef struct packed {
        logic [4:0] level;
        logic [4:0] press;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] btn_raw;
    logic [4:0] btn_level;
    logic [4:0] btn_press;
    logic       any_dir;

    int tests_run = 0;
    int tests_failed = 0;

    exp_t       exp_q[$];
    logic [4:0] pipe[$];
    logic [4:0] win[$];
    logic [4:0] m_d;
    logic [4:1] m_own;

    btn_conditioner #(.DEBOUNCE_CYCLES(DEB), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .any_dir  (any_dir)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Reference: a raw value reaches s2 two edges later; a bit of d flips once the
    // last DEB s2 samples since reset all disagree with it.
    task automatic model_step();
        logic [4:0] s2_now;
        logic [4:0] d_new;
        logic [4:1] own_new;
        logic       stable;
        exp_t       e;
        if (!rst) begin
            pipe = {5'b0, 5'b0};
            win.delete();
            m_d = '0;
            m_own = '0;
            e = '0;
        end else begin
            s2_now = pipe.pop_front();
            pipe.push_back(btn_raw);
            win.push_back(s2_now);
            if (win.size() > DEB) void'(win.pop_front());
            d_new = m_d;
            if (win.size() == DEB) begin
                for (int i = 0; i < 5; i++) begin
                    stable = 1'b1;
                    foreach (win[j]) if (win[j][i] == m_d[i]) stable = 1'b0;
                    if (stable) d_new[i] = ~m_d[i];
                end
            end
`ifdef BTN_DIR_ONEHOT_EN
            if (m_own != 0 && (m_own & d_new[4:1]) != 0) begin
                own_new = m_own;
            end else begin
                own_new = '0;
                for (int k = 1; k <= 4; k++) if (d_new[k] && own_new == 0) own_new[k] = 1'b1;
            end
            e.level = {own_new, d_new[0]};
            e.press = {(own_new != m_own) ? own_new : 4'b0000, d_new[0] & ~m_d[0]};
            m_own = own_new;
`else
            e.level = d_new;
            e.press = d_new & ~m_d;
`endif
            m_d = d_new;
        end
        exp_q.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Monitor: one expectation per edge, compared half a cycle later.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("btn_level", btn_level, e.level);
            check("btn_press", btn_press, e.press);
            check("any_dir", {4'b0, any_dir}, {4'b0, |e.level[4:1]});
        end
    end

    task automatic hold(input logic [4:0] raw, input int n);
        btn_raw = raw;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [4:0] cur;
        rst = 1'b0;
        btn_raw = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;

        hold(5'b00010, 10);                   // single press and hold
        hold(5'b00000, 10);
        hold(5'b01000, 3);                    // glitchy right press
        hold(5'b00000, 1);
        hold(5'b01000, 3);
        hold(5'b00000, 10);
        hold(5'b00010, 10);                   // up owns, down added, up released
        hold(5'b10010, 10);
        hold(5'b10000, 10);
        hold(5'b00000, 10);
        hold(5'b01100, 10);                   // simultaneous left+right
        hold(5'b00000, 10);
        hold(5'b00010, 10);                   // centre alongside up
        hold(5'b00011, 10);
        hold(5'b00000, 10);
        hold(5'b00010, 3);                    // reset mid-debounce
        pulse_reset();
        hold(5'b00010, 10);
        hold(5'b00000, 10);

        cur = '0;
        for (int seg = 0; seg < 400; seg++) begin
            if ($urandom_range(0, 1) == 0) cur = 5'($urandom_range(0, 31));
            else cur[$urandom_range(0, 4)] ^= 1'b1;
            if ($urandom_range(0, 39) == 0) pulse_reset();
            hold(cur, $urandom_range(1, 9));
        end

        hold(5'b00000, 12);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
